// File: rtl/controlador_memoria_if.sv
// -----------------------------------------------------------------------------
// controlador_memoria_if
//
// Bus between the pipeline (fetch port + data port) and the unified memory
// responder.
//
// Handshake: a requester raises req* with its address (and, for the data
// port, escreveDado/dadoEscrita) and holds all of them stable until it sees
// the matching pronto* pulse. pronto* is high for exactly one cycle, and
// instrucao/dadoLido are valid from that cycle on until the next completion on
// the same port. The responder samples the request only while idle. After
// sampling, the request inputs are ignored. A request that is dropped before
// it is sampled is never served.
//
// Signals:
//   reqInst, addrInst                          fetch request / byte address
//   reqDado, escreveDado, addrDado, dadoEscrita data request / write flag /
//                                              byte address / write data
//   prontoInst, instrucao                      fetch completion pulse / word
//   prontoDado, dadoLido                       data completion pulse / word
//   ocupado                                    stall request to hazard unit
//   erroAlinhamento                            sticky misaligned-access flag
// -----------------------------------------------------------------------------
interface controlador_memoria_if;
    logic        reqInst;
    logic [31:0] addrInst;
    logic        reqDado;
    logic        escreveDado;
    logic [31:0] addrDado;
    logic [31:0] dadoEscrita;
    logic        prontoInst;
    logic [31:0] instrucao;
    logic        prontoDado;
    logic [31:0] dadoLido;
    logic        ocupado;
    logic        erroAlinhamento;

    modport master (
        output reqInst, addrInst, reqDado, escreveDado, addrDado, dadoEscrita,
        input  prontoInst, instrucao, prontoDado, dadoLido, ocupado, erroAlinhamento
    );

    modport slave (
        input  reqInst, addrInst, reqDado, escreveDado, addrDado, dadoEscrita,
        output prontoInst, instrucao, prontoDado, dadoLido, ocupado, erroAlinhamento
    );
endinterface

// File: rtl/controlador_memoria.sv
// -----------------------------------------------------------------------------
// controlador_memoria
//
// Unified word-addressed memory that serves the fetch port and the data port
// with a fixed multi-cycle latency. Data accesses win arbitration by default.
// A "fetch is owed" flag lets fetch win the next grant after it has lost once,
// so fetch cannot starve.
//
// Ports:
//   Clock     sole clock, rising edge
//   Reset     synchronous, active-high; clears state and outputs, not the array
//   bus       controlador_memoria_if.slave (requests in, completions out)
//   o_estado  current FSM state (debug)
//
// Parameters:
//   ADDR_W    word-address width; the array holds 2**ADDR_W 32-bit words
//   LATENCIA  cycles from request sample to completion, 1..16
// -----------------------------------------------------------------------------
module controlador_memoria #(
    parameter int ADDR_W   = 8,
    parameter int LATENCIA = 2
) (
    input  logic                 Clock,
    input  logic                 Reset,
    controlador_memoria_if.slave bus,
    output logic [1:0]           o_estado
);
    localparam logic [1:0] OCIOSO   = 2'd0;
    localparam logic [1:0] ACESSO   = 2'd1;
    localparam logic [1:0] RESPOSTA = 2'd2;

    localparam logic [3:0] CARGA = 4'(LATENCIA - 1);

    logic [31:0]       r_mem [0:(2**ADDR_W)-1];

    logic [1:0]        r_estado;
    logic [3:0]        r_cont;
    logic              r_devendo;      // fetch lost a grant and is owed the next one
    logic              r_porta_inst;   // latched winner: 1 = fetch, 0 = data
    logic              r_escreve;
    logic              r_desalinhado;
    logic [ADDR_W-1:0] r_indice;
    logic [31:0]       r_dado;

    logic              r_pronto_inst;
    logic              r_pronto_dado;
    logic [31:0]       r_instrucao;
    logic [31:0]       r_dado_lido;
    logic              r_erro;

    logic              w_req;
    logic              w_ganha_inst;
    logic [31:0]       w_addr;
    logic [31:0]       w_palavra;
    logic              w_unused;

    assign w_req        = bus.reqInst | bus.reqDado;
    assign w_ganha_inst = bus.reqInst & (~bus.reqDado | r_devendo);
    assign w_addr       = w_ganha_inst ? bus.addrInst : bus.addrDado;
    // A misaligned read delivers zero instead of the array word.
    assign w_palavra    = r_desalinhado ? 32'h0000_0000 : r_mem[r_indice];
    // Upper address bits alias; they are intentionally ignored.
    assign w_unused     = ^w_addr[31:ADDR_W+2];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_estado      <= OCIOSO;
            r_cont        <= 4'd0;
            r_devendo     <= 1'b0;
            r_porta_inst  <= 1'b0;
            r_escreve     <= 1'b0;
            r_desalinhado <= 1'b0;
            r_indice      <= '0;
            r_dado        <= 32'h0;
            r_pronto_inst <= 1'b0;
            r_pronto_dado <= 1'b0;
            r_instrucao   <= 32'h0;
            r_dado_lido   <= 32'h0;
            r_erro        <= 1'b0;
        end else begin
            r_pronto_inst <= 1'b0;
            r_pronto_dado <= 1'b0;
            case (r_estado)
                OCIOSO: begin
                    if (w_req) begin
                        r_porta_inst  <= w_ganha_inst;
                        r_escreve     <= ~w_ganha_inst & bus.escreveDado;
                        r_indice      <= w_addr[ADDR_W+1:2];
                        r_desalinhado <= |w_addr[1:0];
                        r_dado        <= bus.dadoEscrita;
                        r_cont        <= CARGA;
                        // The flag remembers a fetch that lost to data. It
                        // clears only when fetch actually gets a grant.
                        if (w_ganha_inst) begin
                            r_devendo <= 1'b0;
                        end else if (bus.reqInst) begin
                            r_devendo <= 1'b1;
                        end
                        r_estado <= (LATENCIA == 1) ? RESPOSTA : ACESSO;
                    end
                end
                ACESSO: begin
                    r_cont <= r_cont - 4'd1;
                    if (r_cont == 4'd1) begin
                        r_estado <= RESPOSTA;
                    end
                end
                RESPOSTA: begin
                    if (r_porta_inst) begin
                        r_pronto_inst <= 1'b1;
                        r_instrucao   <= w_palavra;
                    end else begin
                        r_pronto_dado <= 1'b1;
                        if (!r_escreve) begin
                            r_dado_lido <= w_palavra;
                        end
                    end
                    r_erro   <= r_erro | r_desalinhado;
                    r_estado <= OCIOSO;
                end
                default: r_estado <= OCIOSO;
            endcase
        end
    end

    // The array has no reset so it can map onto RAM. A Reset on the
    // completing edge still blocks the write, which aborts the access.
    always_ff @(posedge Clock) begin
        if (!Reset && r_estado == RESPOSTA && !r_porta_inst && r_escreve && !r_desalinhado) begin
            r_mem[r_indice] <= r_dado;
        end
    end

    assign bus.prontoInst      = r_pronto_inst;
    assign bus.instrucao       = r_instrucao;
    assign bus.prontoDado      = r_pronto_dado;
    assign bus.dadoLido        = r_dado_lido;
    assign bus.erroAlinhamento = r_erro;
    assign bus.ocupado         = (r_estado == ACESSO) | ((r_estado == OCIOSO) & w_req);
    assign o_estado            = r_estado;
endmodule

// File: tb/tb_controlador_memoria.sv
module tb_controlador_memoria;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Three instances that differ only in latency: index 0 -> 1, 1 -> 2, 2 -> 4.
    logic        rst   [3];
    logic        req_i [3];
    logic [31:0] a_i   [3];
    logic        req_d [3];
    logic        we    [3];
    logic [31:0] a_d   [3];
    logic [31:0] wd    [3];
    logic        p_i   [3];
    logic [31:0] ins   [3];
    logic        p_d   [3];
    logic [31:0] rd    [3];
    logic        ocp   [3];
    logic        err   [3];
    logic [1:0]  st    [3];

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 4);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        controlador_memoria_if bus_i ();
        assign bus_i.reqInst     = req_i[g];
        assign bus_i.addrInst    = a_i[g];
        assign bus_i.reqDado     = req_d[g];
        assign bus_i.escreveDado = we[g];
        assign bus_i.addrDado    = a_d[g];
        assign bus_i.dadoEscrita = wd[g];
        assign p_i[g] = bus_i.prontoInst;
        assign ins[g] = bus_i.instrucao;
        assign p_d[g] = bus_i.prontoDado;
        assign rd[g]  = bus_i.dadoLido;
        assign ocp[g] = bus_i.ocupado;
        assign err[g] = bus_i.erroAlinhamento;
        controlador_memoria #(.ADDR_W(AW), .LATENCIA(lat_of(g))) u_dut (
            .Clock    (clk),
            .Reset    (rst[g]),
            .bus      (bus_i),
            .o_estado (st[g])
        );
    end

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem_m [int];   // key = instance*1024 + word index
    logic [31:0] last_inst [3];
    logic [31:0] last_dado [3];
    logic        err_m [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int key_of(input int d, input logic [31:0] a);
        return d * 1024 + int'(a[AW+1:2]);
    endfunction

    function automatic logic [31:0] model_read(input int d, input logic [31:0] a);
        int k;
        k = key_of(d, a);
        if (a[1:0] != 2'b00) return 32'h0;
        if (mem_m.exists(k)) return mem_m[k];
        return 32'h0;
    endfunction

    task automatic check_outputs(input int d, input string tag);
        check($sformatf("d%0d %s instrucao", d, tag), ins[d], last_inst[d]);
        check($sformatf("d%0d %s dadoLido", d, tag), rd[d], last_dado[d]);
        check($sformatf("d%0d %s erro", d, tag), 32'(err[d]), 32'(err_m[d]));
    endtask

    // One complete access on one port; called at a negedge, returns at the
    // negedge where the completion pulse is visible.
    task automatic access(input int d, input bit is_inst, input bit wr,
                          input logic [31:0] addr, input logic [31:0] wdata);
        int  cyc;
        bit  mis;
        bit  seen;
        mis = (addr[1:0] != 2'b00);
        if (is_inst) begin
            req_i[d] = 1'b1;
            a_i[d]   = addr;
        end else begin
            req_d[d] = 1'b1;
            we[d]    = wr;
            a_d[d]   = addr;
            wd[d]    = wdata;
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            seen = is_inst ? p_i[d] : p_d[d];
        end
        check($sformatf("d%0d latency", d), 32'(cyc - 1), 32'(lat_of(d)));
        check($sformatf("d%0d other pronto", d), 32'(is_inst ? p_d[d] : p_i[d]), 32'h0);
        req_i[d] = 1'b0;
        req_d[d] = 1'b0;
        we[d]    = 1'b0;
        if (mis) err_m[d] = 1'b1;
        if (is_inst) begin
            last_inst[d] = model_read(d, addr);
        end else if (wr) begin
            if (!mis) mem_m[key_of(d, addr)] = wdata;
        end else begin
            last_dado[d] = model_read(d, addr);
        end
        check_outputs(d, "access");
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t_d, t_i, n_exp, cnt_d;
        int grants[$];
        bit owed;
        int win;
        logic [31:0] addr;

        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; req_i[d] = 1'b0; req_d[d] = 1'b0; we[d] = 1'b0;
            a_i[d] = 32'h0; a_d[d] = 32'h0; wd[d] = 32'h0;
            last_inst[d] = 32'h0; last_dado[d] = 32'h0; err_m[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d reset prontoInst", d), 32'(p_i[d]), 32'h0);
            check($sformatf("d%0d reset prontoDado", d), 32'(p_d[d]), 32'h0);
            check($sformatf("d%0d reset ocupado", d), 32'(ocp[d]), 32'h0);
            check($sformatf("d%0d reset estado", d), 32'(st[d]), 32'h0);
            check_outputs(d, "reset");
            rst[d] = 1'b0;
        end
        @(negedge clk);

        // Write then read, latency 2.
        access(1, 0, 1, 32'h10, 32'hDEADBEEF);
        access(1, 0, 0, 32'h10, 32'h0);

        // Aliasing: 0x400 and 0x000 share a word.
        access(1, 0, 1, 32'h400, 32'hA5A5A5A5);
        access(1, 0, 0, 32'h000, 32'h0);

        // Simultaneous requests: data first, fetch LAT+1 cycles later.
        access(1, 0, 1, 32'h14, $urandom);
        req_i[1] = 1'b1; a_i[1] = 32'h10;
        req_d[1] = 1'b1; we[1] = 1'b0; a_d[1] = 32'h14;
        t_d = 0; t_i = 0;
        for (int c = 1; c <= 2 * (lat_of(1) + 1) + 2; c++) begin
            @(negedge clk);
            if (p_d[1]) t_d = c;
            if (p_i[1]) t_i = c;
            if (c <= 2 * (lat_of(1) + 1))
                check($sformatf("sim ocupado c%0d", c), 32'(ocp[1]),
                      32'((c == lat_of(1)) || (c == 2 * lat_of(1) + 1) ? 0 : 1));
            if (p_d[1]) req_d[1] = 1'b0;
            if (p_i[1]) req_i[1] = 1'b0;
        end
        req_i[1] = 1'b0; req_d[1] = 1'b0;
        check("sim data pulse", 32'(t_d), 32'(1 + lat_of(1)));
        check("sim inst after data", 32'(t_i - t_d), 32'(lat_of(1) + 1));
        last_dado[1] = model_read(1, 32'h14);
        last_inst[1] = model_read(1, 32'h10);
        check_outputs(1, "sim");

        // Fairness at latency 1: both held for 12 cycles.
        access(0, 0, 1, 32'h10, $urandom);
        access(0, 0, 1, 32'h14, $urandom);
        req_i[0] = 1'b1; a_i[0] = 32'h10;
        req_d[0] = 1'b1; we[0] = 1'b0; a_d[0] = 32'h14;
        grants.delete();
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (p_d[0]) grants.push_back(0);
            if (p_i[0]) grants.push_back(1);
            if (c == 12) begin
                req_i[0] = 1'b0; req_d[0] = 1'b0;
            end
        end
        n_exp = 12 / (lat_of(0) + 1);
        check("fair grant count", 32'(grants.size()), 32'(n_exp));
        owed = 1'b0;
        for (int k = 0; k < n_exp; k++) begin
            win  = owed ? 1 : 0;
            owed = (win == 0);
            if (k < grants.size())
                check($sformatf("fair grant %0d", k), 32'(grants[k]), 32'(win));
        end
        last_dado[0] = model_read(0, 32'h14);
        last_inst[0] = model_read(0, 32'h10);
        check_outputs(0, "fair");

        // Misaligned write is dropped; flag is sticky; misaligned fetch gives 0.
        access(1, 0, 1, 32'h13, 32'h12345678);
        access(1, 0, 0, 32'h10, 32'h0);
        access(1, 1, 0, 32'h12, 32'h0);

        // Reset in the middle of an access at latency 4.
        access(2, 0, 1, 32'h20, 32'h11111111);
        access(2, 1, 0, 32'h20, 32'h0);
        access(2, 0, 0, 32'h21, 32'h0);
        access(2, 0, 0, 32'h20, 32'h0);
        req_d[2] = 1'b1; we[2] = 1'b1; a_d[2] = 32'h20; wd[2] = 32'hCAFEF00D;
        cnt_d = 0;
        @(negedge clk); if (p_d[2]) cnt_d++;
        @(negedge clk); if (p_d[2]) cnt_d++;
        rst[2] = 1'b1; req_d[2] = 1'b0; we[2] = 1'b0;
        @(negedge clk);
        last_inst[2] = 32'h0; last_dado[2] = 32'h0; err_m[2] = 1'b0;
        check("rst prontoDado", 32'(p_d[2]), 32'h0);
        check("rst prontoInst", 32'(p_i[2]), 32'h0);
        check("rst ocupado", 32'(ocp[2]), 32'h0);
        check_outputs(2, "rst");
        rst[2] = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (p_d[2]) cnt_d++;
        end
        check("rst no pronto", 32'(cnt_d), 32'h0);
        access(2, 0, 0, 32'h20, 32'h0);

        // Randomized traffic against the model.
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 8; i++) access(d, 0, 1, 32'h40 + 32'(4 * i), $urandom);
            for (int n = 0; n < 30; n++) begin
                addr = (32'h40 + 32'(4 * $urandom_range(0, 7))) | (32'($urandom_range(0, 15)) << 10);
                if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
                case ($urandom_range(0, 3))
                    0:       access(d, 1, 0, addr, 32'h0);
                    1:       access(d, 0, 0, addr, 32'h0);
                    default: access(d, 0, 1, addr, $urandom);
                endcase
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #400000;
        n_errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
